// File: rtl/uart_byte_tx.sv
// rtl/uart_byte_tx.sv - 8N1 UART byte transmitter on a 16x baud tick; even parity bit when UART_TX_PARITY_EN is defined
module uart_byte_tx (
  input  logic       Clk,
  input  logic       Rst_n,
  input  logic [2:0] baud_set,
  input  logic       Send_en,
  input  logic [7:0] data_byte,
  output logic       Rs232_Tx,
  output logic       Tx_Done,
  output logic       uart_state
);

`ifdef UART_TX_PARITY_EN
  localparam logic [7:0] BPS_END = 8'd175;
  typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;
`else
  localparam logic [7:0] BPS_END = 8'd159;
  typedef enum logic [2:0] {IDLE, START, DATA, STOP} state_t;
`endif

  state_t      state;
  state_t      state_nxt;
  logic [8:0]  bps_dr;
  logic [8:0]  divisor;
  logic [8:0]  div_cnt;
  logic [7:0]  bps_cnt;
  logic [7:0]  tx_data;
  logic        accept;
  logic        tick;
  logic        bit_end;
  logic        tx_nxt;
  logic        done_nxt;
  logic        busy_nxt;

  assign accept  = Send_en && !uart_state;
  assign tick    = uart_state && (div_cnt == divisor);
  assign bit_end = tick && (bps_cnt[3:0] == 4'hF);

  // Divider table shared with the receiver; unused codes fall back to 9600
  always_comb begin
    case (baud_set)
      3'd0:    bps_dr = 9'd324;
      3'd1:    bps_dr = 9'd162;
      3'd2:    bps_dr = 9'd80;
      3'd3:    bps_dr = 9'd53;
      3'd4:    bps_dr = 9'd26;
      default: bps_dr = 9'd324;
    endcase
  end

  // Frame counters; divisor and data are frozen at accept so mid-frame input changes are harmless
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      div_cnt <= '0;
      bps_cnt <= '0;
      divisor <= '0;
      tx_data <= '0;
    end else if (accept) begin
      div_cnt <= '0;
      bps_cnt <= '0;
      divisor <= bps_dr;
      tx_data <= data_byte;
    end else if (uart_state) begin
      if (tick) begin
        div_cnt <= '0;
        bps_cnt <= (bps_cnt == BPS_END) ? 8'd0 : bps_cnt + 8'd1;
      end else begin
        div_cnt <= div_cnt + 9'd1;
      end
    end
  end

  // State and registered line/status outputs
  always_ff @(posedge Clk or negedge Rst_n) begin
    if (!Rst_n) begin
      state      <= IDLE;
      Rs232_Tx   <= 1'b1;
      Tx_Done    <= 1'b0;
      uart_state <= 1'b0;
    end else begin
      state      <= state_nxt;
      Rs232_Tx   <= tx_nxt;
      Tx_Done    <= done_nxt;
      uart_state <= busy_nxt;
    end
  end

  // Next state and next line value; the line only changes on 16-tick bit boundaries
  always_comb begin
    state_nxt = state;
    tx_nxt    = Rs232_Tx;
    done_nxt  = 1'b0;
    busy_nxt  = uart_state;
    case (state)
      IDLE: begin
        if (accept) begin
          state_nxt = START;
          tx_nxt    = 1'b0;
          busy_nxt  = 1'b1;
        end
      end
      START: begin
        if (bit_end) begin
          state_nxt = DATA;
          tx_nxt    = tx_data[0];
        end
      end
      DATA: begin
        if (bit_end) begin
          if (bps_cnt[7:4] == 4'd8) begin
`ifdef UART_TX_PARITY_EN
            state_nxt = PARITY;
            tx_nxt    = ^tx_data;
`else
            state_nxt = STOP;
            tx_nxt    = 1'b1;
`endif
          end else begin
            tx_nxt = tx_data[bps_cnt[6:4]];
          end
        end
      end
`ifdef UART_TX_PARITY_EN
      PARITY: begin
        if (bit_end) begin
          state_nxt = STOP;
          tx_nxt    = 1'b1;
        end
      end
`endif
      STOP: begin
        if (tick && (bps_cnt == BPS_END)) begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
          busy_nxt  = 1'b0;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

endmodule
